serial_operand_serializer: RTL
==============================

Name: serial_operand_serializer

Overview:
Upstream feeder for serial_adder_using_logic_operations_only. Accepts two WIDTH-bit parallel operands over a valid/ready handshake and shifts them out LSB-first, one bit per clk, on the adder's a/b inputs. Drives carry_clr into the adder's rst so the carry is zero at the start of every word. Provides bit_idx and last so a downstream collector can reassemble sum.

Parameters:
WIDTH, 8, operand width in bits (>=2)
IDX_W, $clog2(WIDTH), width of bit_idx

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair available
in_ready  output  1  block can accept an operand pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
a  output  1  serial bit of A, to adder a
b  output  1  serial bit of B, to adder b
carry_clr  output  1  to adder rst; high clears adder carry
busy  output  1  word being streamed
bit_idx  output  IDX_W  index of the bit currently on a/b
last  output  1  current a/b bit is bit WIDTH-1

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, SHIFT. FSM state, shift registers and counter are all registered. Outputs decode from registers only, with no combinational path from inputs.
- Reset (rst=1 at an edge): state=IDLE, shift regs=0, count=0. Outputs the following cycle: in_ready=1, a=0, b=0, carry_clr=1, busy=0, bit_idx=0, last=0.
- IDLE: in_ready=1, carry_clr=1, a=b=0, busy=0.
  - in_valid=1 at an edge: load sh_a<=in_a, sh_b<=in_b, count<=0, state<=SHIFT.
- SHIFT: in_ready=0, carry_clr=0, busy=1, a=sh_a[0], b=sh_b[0], bit_idx=count, last=(count==WIDTH-1).
  - Each edge: shift both regs right by one with 0 fill, count<=count+1.
  - At the edge where last=1: state<=IDLE, count<=0.
- Latency: if accepted at edge E, bit 0 is on a/b in the cycle after E. Bit k is on a/b in cycle k after that, k=0..WIDTH-1.
- Throughput: one word per WIDTH+1 cycles. The mandatory IDLE cycle holds carry_clr=1, so the adder carry is 0 for bit 0.
- The carry out of the MSB is discarded. Sums are modulo 2^WIDTH.
- in_valid while in SHIFT: ignored. The source holds in_valid and data until in_ready=1.
- Operand changes while in_valid=1 and in_ready=0 have no effect.
- rst during SHIFT: the word is aborted and not resumed. IDLE outputs appear the next cycle, carry_clr=1.
- rst and in_valid at the same edge: rst wins and nothing is accepted.
- count never exceeds WIDTH-1, so there is no wrap-around inside a word.

Decomposition:
- Package serial_pkg: state_t enum {IDLE, SHIFT}; localparam DEFAULT_WIDTH=8.
- Sub-module piso_shift_reg (parameter WIDTH; ports clk, rst, load, shift, d[WIDTH], q_lsb).
  - Instantiated twice, once per operand.
  - load has priority over shift.
- Top module holds the FSM, the counter and the output decode.

Test Plan:
1. Reset: rst=1 for 2 cycles, then 0 -> in_ready=1, carry_clr=1, a=b=0, busy=0, last=0, bit_idx=0.
2. Single word: in_a=8'hA5, in_b=8'h3C accepted at edge T.
   - Cycles T+1..T+8: a=1,0,1,0,0,1,0,1 and b=0,0,1,1,1,1,0,0.
   - bit_idx=0..7, last only in cycle T+8, carry_clr=0 throughout.
   - Adder sum collected LSB-first = 8'hE1.
3. Back-to-back: in_valid held with 8'hFF+8'h01, then 8'h01+8'h01.
   - Second word accepted at T+9, with carry_clr=1 in that cycle.
   - Sums 8'h00, then 8'h02, which proves the carry was cleared between words.
4. Busy ignore: in_valid pulsed with 8'h55/8'h55 in cycle T+3 of a streaming word.
   - No acceptance, in_ready stays 0, stream bits unchanged.
5. Reset mid-word: rst=1 at T+4.
   - Next cycle: IDLE outputs, in_ready=1, carry_clr=1.
   - A following 8'h03+8'h04 yields sum 8'h07.
6. Sweep: all i,j in 0..11 as operands -> collected sum equals i+j for every pair, with no handshake stalls beyond the single IDLE gap.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial operand serializer.
package serial_pkg;

  // Two-state streaming controller: wait for a word, then shift it out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default operand width used when the parent does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register. Loads a word in parallel and
// presents it LSB-first, shifting right with zero fill. Load has priority
// over shift.
module piso_shift_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_lsb
);

  logic [WIDTH-1:0] r_q;

  // Parallel load, otherwise right shift with zero fill into the MSB.
  // NOTE: the datapath register is reset too, so stale bits from an aborted
  // word can never leak out on the serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign q_lsb = r_q[0];

endmodule : piso_shift_reg

// File: rtl/serial_operand_serializer.sv
// Feeds a serial adder: accepts two parallel operands over valid/ready and
// streams them LSB-first, one bit per clock. carry_clr is high in every idle
// cycle, so the adder carry is zero when bit 0 of each word arrives.
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a,
  output logic             b,
  output logic             carry_clr,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx,
  output logic             last
);

  // Index of the final bit of a word; the counter stops here and never wraps.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_count;

  logic w_idle;
  logic w_shifting;
  logic w_load;
  logic w_at_last;
  logic w_a_lsb;
  logic w_b_lsb;

  assign w_idle     = (r_state == IDLE);
  assign w_shifting = (r_state == SHIFT);
  assign w_load     = w_idle && in_valid;
  assign w_at_last  = (r_count == LAST_IDX);

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sh_a (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shifting),
    .d     (in_a),
    .q_lsb (w_a_lsb)
  );

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sh_b (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shifting),
    .d     (in_b),
    .q_lsb (w_b_lsb)
  );

  // Controller: accept a word in IDLE, count bits in SHIFT, return to IDLE
  // after the last bit so one carry-clearing gap separates consecutive words.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_count <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_at_last) begin
            r_count <= '0;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + IDX_W'(1);
          end
        end
        default: begin
          r_count <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from registers only; no input reaches an output
  // combinationally. Serial bits are gated to zero outside SHIFT.
  assign in_ready  = w_idle;
  assign carry_clr = w_idle;
  assign busy      = w_shifting;
  assign a         = w_shifting && w_a_lsb;
  assign b         = w_shifting && w_b_lsb;
  assign bit_idx   = r_count;
  assign last      = w_shifting && w_at_last;

endmodule : serial_operand_serializer
